// File: rtl/wb_uart_lite.sv
// Wishbone classic 8N1 UART slave: TX/RX FIFOs, sticky overrun/framing flags and a level interrupt.
// The FIFO helper sits in this file so the block stays self-contained.

module wb_uart_lite_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts then.
    assign w_pop_ok  = i_pop & (r_count != '0);
    assign w_push_ok = i_push & ((r_count != FULL_COUNT) | w_pop_ok);

    // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == FULL_COUNT);
endmodule

module wb_uart_lite #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        uart_int
);
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);
    localparam logic [1:0]  ADR_TX = 2'd0, ADR_RX = 2'd1, ADR_ST = 2'd2, ADR_CTRL = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    // Bus side
    logic        r_ack, r_we_q, r_sel0_q, r_rx_hit_q;
    logic [1:0]  r_adr_q;
    logic [7:0]  r_wbyte_q;
    logic [31:0] r_dat_o;
    logic [1:0]  r_ctrl;
    logic        r_ovr, r_frm, r_int;
    logic        w_req, w_wr_tx, w_rd_rx, w_wr_st, w_wr_ctrl;
    logic [31:0] w_rd_data;
    logic        w_unused;

    // TX side
    uart_state_t r_tx_state, w_tx_state_next;
    logic [15:0] r_tx_cnt, w_tx_cnt_next;
    logic [2:0]  r_tx_bit, w_tx_bit_next;
    logic [7:0]  r_tx_shift, w_tx_shift_next;
    logic        w_tx_tick, w_tx_pop, w_tx_empty, w_tx_full;
    logic [7:0]  w_tx_rdata;

    // RX side
    logic        r_rxd_s1, r_rxd_s2, r_rxd_s3;
    uart_state_t r_rx_state, w_rx_state_next;
    logic [15:0] r_rx_cnt, w_rx_cnt_next;
    logic [2:0]  r_rx_bit, w_rx_bit_next;
    logic [7:0]  r_rx_shift, w_rx_shift_next;
    logic        w_rx_tick, w_rx_store, w_rx_stop_bad, w_rx_empty, w_rx_full;
    logic [7:0]  w_rx_rdata;

    assign w_unused = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:8]};

    // Side effects fire in the ack cycle from the request captured one edge earlier.
    assign w_req     = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr_tx   = r_ack & r_we_q & r_sel0_q & (r_adr_q == ADR_TX);
    assign w_rd_rx   = r_ack & ~r_we_q & r_rx_hit_q & (r_adr_q == ADR_RX);
    assign w_wr_st   = r_ack & r_we_q & r_sel0_q & (r_adr_q == ADR_ST);
    assign w_wr_ctrl = r_ack & r_we_q & r_sel0_q & (r_adr_q == ADR_CTRL);

    always_comb begin
        w_rd_data = '0;
        case (wb_adr_i[3:2])
            ADR_RX:   w_rd_data = w_rx_empty ? 32'd0 : {24'd0, w_rx_rdata};
            ADR_ST:   w_rd_data = {27'd0, r_ovr, r_frm, ~w_rx_empty, w_tx_full, w_tx_empty};
            ADR_CTRL: w_rd_data = {30'd0, r_ctrl};
            default:  w_rd_data = '0;
        endcase
    end

    wb_uart_lite_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .i_clk(wb_clk_i), .i_rst(wb_rst_i),
        .i_push(w_wr_tx), .i_push_data(r_wbyte_q),
        .i_pop(w_tx_pop), .o_pop_data(w_tx_rdata),
        .o_empty(w_tx_empty), .o_full(w_tx_full)
    );

    wb_uart_lite_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .i_clk(wb_clk_i), .i_rst(wb_rst_i),
        .i_push(w_rx_store), .i_push_data(r_rx_shift),
        .i_pop(w_rd_rx), .o_pop_data(w_rx_rdata),
        .o_empty(w_rx_empty), .o_full(w_rx_full)
    );

    assign w_tx_tick = (r_tx_cnt == DIV_LAST);

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_cnt_next   = r_tx_cnt + 16'd1;
        w_tx_bit_next   = r_tx_bit;
        w_tx_shift_next = r_tx_shift;
        w_tx_pop        = 1'b0;
        case (r_tx_state)
            S_IDLE: begin
                w_tx_cnt_next = '0;
                if (!w_tx_empty) begin
                    w_tx_pop        = 1'b1;
                    w_tx_shift_next = w_tx_rdata;
                    w_tx_state_next = S_START;
                end
            end
            S_START: if (w_tx_tick) begin
                w_tx_cnt_next   = '0;
                w_tx_bit_next   = '0;
                w_tx_state_next = S_DATA;
            end
            S_DATA: if (w_tx_tick) begin
                w_tx_cnt_next   = '0;
                w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
                w_tx_bit_next   = r_tx_bit + 3'd1;
                if (r_tx_bit == 3'd7) w_tx_state_next = S_STOP;
            end
            S_STOP: if (w_tx_tick) begin
                w_tx_cnt_next = '0;
                if (!w_tx_empty) begin
                    w_tx_pop        = 1'b1;
                    w_tx_shift_next = w_tx_rdata;
                    w_tx_state_next = S_START;
                end else begin
                    w_tx_state_next = S_IDLE;
                end
            end
            default: w_tx_state_next = S_IDLE;
        endcase
    end

    assign w_rx_tick = (r_rx_cnt == DIV_LAST);

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_cnt_next   = r_rx_cnt + 16'd1;
        w_rx_bit_next   = r_rx_bit;
        w_rx_shift_next = r_rx_shift;
        w_rx_store      = 1'b0;
        w_rx_stop_bad   = 1'b0;
        case (r_rx_state)
            S_IDLE: begin
                w_rx_cnt_next = '0;
                if (r_rxd_s3 && !r_rxd_s2) w_rx_state_next = S_START;
            end
            // Half a bit after the falling edge the line must still be low, else it was a glitch.
            S_START: if (r_rx_cnt == HALF_LAST) begin
                w_rx_cnt_next   = '0;
                w_rx_bit_next   = '0;
                w_rx_state_next = r_rxd_s2 ? S_IDLE : S_DATA;
            end
            S_DATA: if (w_rx_tick) begin
                w_rx_cnt_next   = '0;
                w_rx_shift_next = {r_rxd_s2, r_rx_shift[7:1]};
                w_rx_bit_next   = r_rx_bit + 3'd1;
                if (r_rx_bit == 3'd7) w_rx_state_next = S_STOP;
            end
            S_STOP: if (w_rx_tick) begin
                w_rx_store      = 1'b1;
                w_rx_stop_bad   = ~r_rxd_s2;
                w_rx_state_next = S_IDLE;
            end
            default: w_rx_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack      <= 1'b0;
            r_dat_o    <= '0;
            r_we_q     <= 1'b0;
            r_sel0_q   <= 1'b0;
            r_rx_hit_q <= 1'b0;
            r_adr_q    <= '0;
            r_wbyte_q  <= '0;
            r_ctrl     <= '0;
            r_ovr      <= 1'b0;
            r_frm      <= 1'b0;
            r_int      <= 1'b0;
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_rxd_s1   <= 1'b1;
            r_rxd_s2   <= 1'b1;
            r_rxd_s3   <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_ack   <= w_req;
            r_dat_o <= (w_req && !wb_we_i) ? w_rd_data : 32'd0;
            if (w_req) begin
                r_we_q     <= wb_we_i;
                r_sel0_q   <= wb_sel_i[0];
                r_adr_q    <= wb_adr_i[3:2];
                r_wbyte_q  <= wb_dat_i[7:0];
                r_rx_hit_q <= ~w_rx_empty;
            end
            if (w_wr_ctrl) r_ctrl <= r_wbyte_q[1:0];
            if (w_rx_store && w_rx_full && !w_rd_rx) r_ovr <= 1'b1;
            else if (w_wr_st && r_wbyte_q[4])        r_ovr <= 1'b0;
            if (w_rx_store && w_rx_stop_bad)         r_frm <= 1'b1;
            else if (w_wr_st && r_wbyte_q[3])        r_frm <= 1'b0;
            r_int <= (r_ctrl[0] & ~w_rx_empty) |
                     (r_ctrl[1] & w_tx_empty & (r_tx_state == S_IDLE));
            r_tx_state <= w_tx_state_next;
            r_tx_cnt   <= w_tx_cnt_next;
            r_tx_bit   <= w_tx_bit_next;
            r_tx_shift <= w_tx_shift_next;
            r_rxd_s1   <= uart_rxd;
            r_rxd_s2   <= r_rxd_s1;
            r_rxd_s3   <= r_rxd_s2;
            r_rx_state <= w_rx_state_next;
            r_rx_cnt   <= w_rx_cnt_next;
            r_rx_bit   <= w_rx_bit_next;
            r_rx_shift <= w_rx_shift_next;
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat_o;
    assign uart_int = r_int;
    assign uart_txd = (r_tx_state == S_START) ? 1'b0 :
                      (r_tx_state == S_DATA)  ? r_tx_shift[0] : 1'b1;
endmodule

// File: tb/tb_wb_uart_lite.sv
// Bench for wb_uart_lite: a frame-timeline model predicts uart_txd every cycle, and a queue
// model of the RX FIFO and flags predicts register reads; literal values pin key cases.

module tb_wb_uart_lite;
    localparam int DIV   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o;
    logic        uart_txd, uart_int;
    logic        rxd_drv = 1'b1;
    logic        loop = 1'b0;
    logic        w_rxd;

    assign w_rxd = loop ? uart_txd : rxd_drv;

    wb_uart_lite #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .uart_rxd(w_rxd), .uart_txd(uart_txd), .uart_int(uart_int)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // TX model: each accepted byte becomes a frame with the cycle its start bit begins.
    int         m_start[$];
    logic [7:0] m_data[$];
    int         m_last_end = 0;
    // RX model: bytes the CPU will read, plus sticky flags.
    logic [7:0] m_rx_q[$];
    logic       m_ovr = 1'b0;
    logic       m_frm = 1'b0;

    function automatic logic model_txd(input int c);
        foreach (m_start[i]) begin
            if (c >= m_start[i] && c < m_start[i] + 10 * DIV) begin
                int idx;
                idx = (c - m_start[i]) / DIV;
                if (idx == 0) return 1'b0;
                if (idx == 9) return 1'b1;
                return m_data[i][idx-1];
            end
        end
        return 1'b1;
    endfunction

    // Bytes still waiting in the TX FIFO during cycle n.
    function automatic int tx_count(input int n);
        int cnt = 0;
        foreach (m_start[i]) if (m_start[i] > n) cnt++;
        return cnt;
    endfunction

    function automatic logic [31:0] status_exp(input int n);
        return {27'd0, m_ovr, m_frm, (m_rx_q.size() != 0), (tx_count(n) == DEPTH), (tx_count(n) == 0)};
    endfunction

    function automatic logic [31:0] rx_model_pop();
        if (m_rx_q.size() == 0) return 32'd0;
        return {24'd0, m_rx_q.pop_front()};
    endfunction

    task automatic rx_model_store(input logic [7:0] b, input logic stop_bit);
        if (m_rx_q.size() < DEPTH) m_rx_q.push_back(b);
        else m_ovr = 1'b1;
        if (!stop_bit) m_frm = 1'b1;
    endtask

    // Push lands on edge e; a frame starting on that same edge frees a slot.
    task automatic model_push(input logic [7:0] b, input int e);
        int  cnt;
        int  s;
        bit  pop_now;
        cnt = 0;
        pop_now = 1'b0;
        foreach (m_start[i]) begin
            if (m_start[i] >= e) cnt++;
            if (m_start[i] == e) pop_now = 1'b1;
        end
        if (cnt < DEPTH || pop_now) begin
            s = (e + 1 > m_last_end) ? e + 1 : m_last_end;
            m_start.push_back(s);
            m_data.push_back(b);
            m_last_end = s + 10 * DIV;
            if (loop) rx_model_store(b, 1'b1);
        end
    endtask

    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) check("txd", {31'd0, uart_txd}, {31'd0, model_txd(cyc)});
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_access(input logic we, input logic [1:0] a, input logic [31:0] d,
                             output logic [31:0] rd);
        int lat;
        lat = -1;
        rd  = '0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = {28'd0, a, 2'b00}; wb_dat_i = d; wb_sel_i = 4'h1;
        for (int i = 0; i < 4 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o) begin
                lat = i;
                rd  = wb_dat_o;
            end
        end
        check("ack_latency", lat, 0);
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        check("ack_single", {31'd0, wb_ack_o}, 32'd0);
        check("dat_idle", wb_dat_o, 32'd0);
        if (we && lat == 0) begin
            if (a == 2'd0) model_push(d[7:0], cyc);
            if (a == 2'd2) begin
                if (d[4]) m_ovr = 1'b0;
                if (d[3]) m_frm = 1'b0;
            end
        end
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_access(1'b1, a, d, dummy);
    endtask

    task automatic wb_read(input string name, input logic [1:0] a, input logic [31:0] exp,
                           output logic [31:0] rd);
        wb_access(1'b0, a, 32'd0, rd);
        check(name, rd, exp);
    endtask

    task automatic wait_idle();
        while (cyc < m_last_end + 2 * DIV) wait_cyc(1);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd_drv = bits[i];
            wait_cyc(DIV);
        end
        rxd_drv = 1'b1;
        rx_model_store(b, stop_bit);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [9:0]  pat;
        rst = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        wait_cyc(3);
        check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_txd", {31'd0, uart_txd}, 32'd1);
        check("rst_int", {31'd0, uart_int}, 32'd0);
        rst = 1'b0;
        wait_cyc(1);
        chk_en = 1'b1;
        wb_read("status_rst", 2'd2, status_exp(cyc), rd);
        check("status_rst_lit", rd, 32'h1);
        wb_read("ctrl_rst", 2'd3, 32'd0, rd);

        // Single byte 0x55: start, LSB-first data, stop, each DIV cycles.
        wb_write(2'd0, 32'h55);
        pat = 10'h2AA;
        wait_cyc(2);
        for (int k = 0; k < 10; k++) begin
            check("tx55_bit", {31'd0, uart_txd}, {31'd0, pat[k]});
            wait_cyc(DIV);
        end
        wait_idle();
        wb_read("status_txdone", 2'd2, status_exp(cyc), rd);
        check("status_txdone_lit", rd, 32'h1);

        // Loopback two bytes.
        loop = 1'b1;
        wb_write(2'd0, 32'hA3);
        wb_write(2'd0, 32'h5C);
        wb_read("txdata_rd", 2'd0, 32'd0, rd);
        wait_idle();
        wb_read("status_rx", 2'd2, status_exp(cyc), rd);
        check("status_rx_lit", rd, 32'h5);
        wb_read("rx_first", 2'd1, rx_model_pop(), rd);
        check("rx_first_lit", rd, 32'hA3);
        wb_read("rx_second", 2'd1, rx_model_pop(), rd);
        check("rx_second_lit", rd, 32'h5C);
        wb_read("rx_empty", 2'd1, rx_model_pop(), rd);
        wb_write(2'd1, 32'hFF);
        wb_read("rx_empty_after_wr", 2'd1, rx_model_pop(), rd);
        check("rx_empty_lit", rd, 32'd0);
        loop = 1'b0;

        // Fill TX FIFO while busy: one frame in flight, eight queued, last push dropped.
        for (int i = 0; i < 10; i++) wb_write(2'd0, 32'h80 + i);
        wb_read("status_full", 2'd2, status_exp(cyc), rd);
        check("status_full_lit", rd, 32'h2);
        wait_idle();

        // RX overrun: nine frames with no reads.
        for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 1'b1);
        wait_cyc(3 * DIV);
        wb_read("status_ovr", 2'd2, status_exp(cyc), rd);
        check("status_ovr_lit", rd, 32'h15);
        for (int i = 0; i < 8; i++) begin
            wb_read("rx_ovr_data", 2'd1, rx_model_pop(), rd);
            check("rx_ovr_data_lit", rd, 32'h10 + i);
        end
        wb_write(2'd2, 32'h18);
        wb_read("status_clr", 2'd2, status_exp(cyc), rd);
        check("status_clr_lit", rd, 32'h1);

        // Framing error: byte still stored.
        send_frame(8'h3C, 1'b0);
        wait_cyc(3 * DIV);
        wb_read("status_frm", 2'd2, status_exp(cyc), rd);
        check("status_frm_lit", rd, 32'hD);
        wb_read("rx_frm_data", 2'd1, rx_model_pop(), rd);
        check("rx_frm_data_lit", rd, 32'h3C);
        wb_write(2'd2, 32'h18);

        // One-clock glitch on idle line is rejected.
        rxd_drv = 1'b0;
        wait_cyc(1);
        rxd_drv = 1'b1;
        wait_cyc(12 * DIV);
        wb_read("status_glitch", 2'd2, status_exp(cyc), rd);
        check("status_glitch_lit", rd, 32'h1);

        // Interrupts.
        wb_write(2'd3, 32'hFFFF_FFFD);
        wb_read("ctrl_rd", 2'd3, 32'h1, rd);
        check("int_idle", {31'd0, uart_int}, 32'd0);
        send_frame(8'h7E, 1'b1);
        wait_cyc(3 * DIV);
        check("int_rx", {31'd0, uart_int}, 32'd1);
        wb_read("rx_int_data", 2'd1, rx_model_pop(), rd);
        check("int_hold", {31'd0, uart_int}, 32'd1);
        wait_cyc(1);
        check("int_clr", {31'd0, uart_int}, 32'd0);
        wb_write(2'd3, 32'h2);
        wait_cyc(1);
        check("int_tx", {31'd0, uart_int}, 32'd1);
        wb_write(2'd3, 32'h0);
        wait_cyc(1);
        check("int_off", {31'd0, uart_int}, 32'd0);

        // Reset in the middle of a frame returns the line high at once.
        wb_write(2'd0, 32'h00);
        wait_cyc(12);
        chk_en = 1'b0;
        rst = 1'b1;
        wait_cyc(1);
        check("rst_mid_txd", {31'd0, uart_txd}, 32'd1);
        check("rst_mid_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_mid_int", {31'd0, uart_int}, 32'd0);
        rst = 1'b0;
        m_start.delete();
        m_data.delete();
        m_last_end = 0;
        m_rx_q.delete();
        m_ovr = 1'b0;
        m_frm = 1'b0;
        chk_en = 1'b1;
        wb_read("status_post_rst", 2'd2, status_exp(cyc), rd);
        check("status_post_rst_lit", rd, 32'h1);
        wait_cyc(12 * DIV);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
